nark_data_mem_responder: RTL

//   Memory-side responder for the NARK data-memory port; it answers the load/store requests the pipeline raises in M.
//   It accepts one request per transaction over a valid/ready handshake and inserts programmable wait states.
//   It returns read data or a write acknowledge over a valid/ready response channel.
//   Out-of-range accesses are flagged with an error and never touch storage.

---
 rtl/nark_data_mem_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/nark_data_mem_responder.sv
// Data-memory responder for the NARK M-stage port: one outstanding load/store,
// programmable wait states, registered response with out-of-range error flag.
module nark_data_mem_responder #(
    parameter int BITS        = 24,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BITS-1:0]   req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BITS-1:0]   rsp_rdata,
    output logic              rsp_err
);
    localparam int              IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT  = DEPTH[ADDR_W:0];
    localparam logic [3:0]      WAIT_L = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept, enter_resp;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BITS-1:0]   wdata_q;
    logic [BITS-1:0]   mem [DEPTH];
    logic [IW-1:0]     idx;

    assign idx       = addr_q[IW-1:0];
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // The counter covers the wait states; the final WAIT cycle with cnt==0 is
    // the storage-access cycle, giving accept-to-valid of WAIT_CYCLES+1 edges.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
                cnt_nxt   = WAIT_L;
            end
            WAIT: if (cnt == 4'd0) begin
                enter_resp = 1'b1;
                state_nxt  = RESP;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= ({1'b0, req_addr} >= LIMIT);
            end
            if (enter_resp) begin
                rsp_err   <= err_q;
                rsp_rdata <= (!we_q && !err_q) ? mem[idx] : '0;
            end else if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    // Storage is never reset; a store commits on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && we_q && !err_q) mem[idx] <= wdata_q;
    end
endmodule
